// File: rtl/key_cond_pkg.sv
// key_cond_pkg: shared types and default timing constants for the key
// conditioner (debounce FSM state encoding, default debounce/long-press counts).
package key_cond_pkg;

  // Per-channel debounce state, 2-bit encoding.
  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    ARMING    = 2'd1,
    PRESSED   = 2'd2,
    DISARMING = 2'd3
  } key_state_t;

  // 10 ms debounce and 1 s long-press at 100 MHz.
  localparam int unsigned KC_DEB_CYCLES  = 1_000_000;
  localparam int unsigned KC_LONG_CYCLES = 100_000_000;

endpackage

// File: rtl/key_debounce.sv
// key_debounce: one key channel. Two-flop synchronizer, glitch-rejecting
// debounce FSM, registered level and single-cycle press/release/long pulses.
// Optional feature macro: KEY_LONGPRESS_EN (long-press counter and pulse).
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   key_n         - raw active-low button, asynchronous to clk
//   key_lvl       - debounced level, 1 = pressed
//   key_press     - one-cycle pulse on accepted press
//   key_release   - one-cycle pulse on accepted release
//   key_long      - one-cycle pulse once per press after a long hold
module key_debounce
  import key_cond_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = KC_DEB_CYCLES,
  parameter int unsigned LONG_CYCLES = KC_LONG_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_lvl,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int unsigned DW = $clog2(DEB_CYCLES);

  // Elaboration-time parameter sanity checks.
  if (DEB_CYCLES < 2) begin : g_deb_chk
    $error("DEB_CYCLES must be >= 2");
  end
  if (LONG_CYCLES < 2) begin : g_long_chk
    $error("LONG_CYCLES must be >= 2");
  end

  logic [1:0]    sync_q, sync_d;
  key_state_t    state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          lvl_q, lvl_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          s;

`ifdef KEY_LONGPRESS_EN
  localparam int unsigned LW = $clog2(LONG_CYCLES);
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic          long_done_q, long_done_d;
  logic          long_q, long_d;
`endif

  // Synchronizer resets to released (1); s is the active-high sampled key.
  assign sync_d = {sync_q[0], key_n};
  assign s      = ~sync_q[1];

  // Next-state, counters and event pulses.
  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef KEY_LONGPRESS_EN
    lcnt_d      = lcnt_q;
    long_done_d = long_done_q;
    long_d      = 1'b0;
    // Long counter runs while the key is logically held, including
    // through a rejected release glitch.
    if (state_q == PRESSED || state_q == DISARMING) begin
      if (lcnt_q != LW'(LONG_CYCLES - 1)) begin
        lcnt_d = lcnt_q + LW'(1);
      end else if (!long_done_q) begin
        long_d      = 1'b1;
        long_done_d = 1'b1;
      end
    end
`endif
    case (state_q)
      RELEASED: begin
        if (s) begin
          state_d = ARMING;
          dcnt_d  = '0;
        end
      end
      ARMING: begin
        if (!s) begin
          state_d = RELEASED;
        end else if (dcnt_q == DW'(DEB_CYCLES - 1)) begin
          state_d = PRESSED;
          press_d = 1'b1;
`ifdef KEY_LONGPRESS_EN
          lcnt_d      = '0;
          long_done_d = 1'b0;
`endif
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = DISARMING;
          dcnt_d  = '0;
        end
      end
      DISARMING: begin
        if (s) begin
          state_d = PRESSED;
        end else if (dcnt_q == DW'(DEB_CYCLES - 1)) begin
          state_d   = RELEASED;
          release_d = 1'b1;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      default: state_d = RELEASED;
    endcase
    lvl_d = (state_d == PRESSED) || (state_d == DISARMING);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= 2'b11;
      state_q   <= RELEASED;
      dcnt_q    <= '0;
      lvl_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      lvl_q     <= lvl_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

`ifdef KEY_LONGPRESS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lcnt_q      <= '0;
      long_done_q <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      lcnt_q      <= lcnt_d;
      long_done_q <= long_done_d;
      long_q      <= long_d;
    end
  end
  assign key_long = long_q;
`else
  assign key_long = 1'b0;
`endif

  assign key_lvl     = lvl_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: NKEYS independent debounced key channels feeding the
// LED counter. Optional feature macro: KEY_LONGPRESS_EN (long-press events).
// Ports:
//   CLK, RST      - clock, synchronous active-high reset
//   KEY_N         - raw active-low buttons
//   KEY_LVL       - debounced levels, 1 = pressed
//   KEY_PRESS     - per-key one-cycle press pulses
//   KEY_RELEASE   - per-key one-cycle release pulses
//   KEY_LONG      - per-key one-cycle long-press pulses (0 when disabled)
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int unsigned NKEYS       = 2,
  parameter int unsigned DEB_CYCLES  = KC_DEB_CYCLES,
  parameter int unsigned LONG_CYCLES = KC_LONG_CYCLES
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [NKEYS-1:0] KEY_N,
  output logic [NKEYS-1:0] KEY_LVL,
  output logic [NKEYS-1:0] KEY_PRESS,
  output logic [NKEYS-1:0] KEY_RELEASE,
  output logic [NKEYS-1:0] KEY_LONG
);

  // One fully independent channel per key.
  for (genvar i = 0; i < int'(NKEYS); i++) begin : g_key
    key_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES)
    ) u_key_debounce (
      .clk        (CLK),
      .rst        (RST),
      .key_n      (KEY_N[i]),
      .key_lvl    (KEY_LVL[i]),
      .key_press  (KEY_PRESS[i]),
      .key_release(KEY_RELEASE[i]),
      .key_long   (KEY_LONG[i])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed checks of reset, clean press/release, bounce
// rejection, long press and release-glitch rejection with DEB=8, LONG=32.
// Edge 0 of each phase is the first rising edge that samples the new input.
module tb_key_conditioner;

`ifdef KEY_LONGPRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [1:0] key_n;
  logic [1:0] key_lvl, key_press, key_release, key_long;

  int n_checks = 0;
  int n_pass   = 0;

  key_conditioner #(
    .NKEYS      (2),
    .DEB_CYCLES (8),
    .LONG_CYCLES(32)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .KEY_N      (key_n),
    .KEY_LVL    (key_lvl),
    .KEY_PRESS  (key_press),
    .KEY_RELEASE(key_release),
    .KEY_LONG   (key_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  task automatic chk_outs(input string tag, input int n, input logic [1:0] lvl,
                          input logic [1:0] prs, input logic [1:0] rel,
                          input logic [1:0] lng);
    check($sformatf("%s@%0d lvl", tag, n), key_lvl, lvl);
    check($sformatf("%s@%0d press", tag, n), key_press, prs);
    check($sformatf("%s@%0d release", tag, n), key_release, rel);
    check($sformatf("%s@%0d long", tag, n), key_long, lng);
  endtask

  // Advance one rising edge, then sample away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Release all keys and check the release pulse on mask m.
  task automatic release_phase(input string tag, input logic [1:0] m);
    key_n = 2'b11;
    for (int n = 0; n < 20; n++) begin
      step();
      chk_outs(tag, n, (n < 10) ? m : 2'b00, 2'b00, (n == 10) ? m : 2'b00, 2'b00);
    end
  endtask

  initial begin
    rst   = 1'b1;
    key_n = 2'b00;

    // Reset held with both keys pressed.
    for (int i = 0; i < 3; i++) begin
      step();
      chk_outs("reset", i, 2'b00, 2'b00, 2'b00, 2'b00);
    end
    rst = 1'b0;
    for (int n = 0; n < 15; n++) begin
      step();
      chk_outs("rst_press", n, (n >= 10) ? 2'b11 : 2'b00, (n == 10) ? 2'b11 : 2'b00,
               2'b00, 2'b00);
    end
    release_phase("rst_rel", 2'b11);

    // Clean press on key 0.
    key_n = 2'b10;
    for (int n = 0; n < 20; n++) begin
      step();
      chk_outs("clean", n, (n >= 10) ? 2'b01 : 2'b00, (n == 10) ? 2'b01 : 2'b00,
               2'b00, 2'b00);
    end
    release_phase("clean_rel", 2'b01);

    // Bounce: 5 low / 2 high, three times, then a solid hold.
    for (int r = 0; r < 3; r++) begin
      key_n = 2'b10;
      for (int n = 0; n < 5; n++) begin
        step();
        chk_outs($sformatf("bounce_lo%0d", r), n, 2'b00, 2'b00, 2'b00, 2'b00);
      end
      key_n = 2'b11;
      for (int n = 0; n < 2; n++) begin
        step();
        chk_outs($sformatf("bounce_hi%0d", r), n, 2'b00, 2'b00, 2'b00, 2'b00);
      end
    end
    key_n = 2'b10;
    for (int n = 0; n < 20; n++) begin
      step();
      chk_outs("bounce_hold", n, (n >= 10) ? 2'b01 : 2'b00, (n == 10) ? 2'b01 : 2'b00,
               2'b00, 2'b00);
    end
    release_phase("bounce_rel", 2'b01);

    // Long press on key 1: long fires once at edge 42.
    key_n = 2'b01;
    for (int n = 0; n < 60; n++) begin
      step();
      chk_outs("long", n, (n >= 10) ? 2'b10 : 2'b00, (n == 10) ? 2'b10 : 2'b00, 2'b00,
               (LONG_EN && n == 42) ? 2'b10 : 2'b00);
    end
    release_phase("long_rel", 2'b10);

    // Release glitch on key 0: 3-cycle high while pressed is rejected.
    for (int n = 0; n < 60; n++) begin
      key_n = (n >= 20 && n <= 22) ? 2'b11 : 2'b10;
      step();
      chk_outs("glitch", n, (n >= 10) ? 2'b01 : 2'b00, (n == 10) ? 2'b01 : 2'b00, 2'b00,
               (LONG_EN && n == 42) ? 2'b01 : 2'b00);
    end
    release_phase("glitch_rel", 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
